// File: rtl/ext_mem_bridge_n.sv
// CPU word request to 8-bit strobe/ack pin-bus bridge: address bytes then data bytes,
// LSB first, four-phase handshake per byte, with a per-edge ack timeout that aborts.
module ext_mem_bridge_n #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              request,
    input  logic              request_type,
    input  logic [ADDR_W-1:0] request_address,
    input  logic [DATA_W-1:0] memory_write,
    output logic [DATA_W-1:0] data_out,
    output logic              memory_ready,
    output logic              write_complete,
    output logic              bus_error,
    output logic              busy,
    output logic [7:0]        bus_out,
    output logic [7:0]        bus_oe,
    input  logic [7:0]        bus_in,
    output logic              strobe,
    output logic [1:0]        phase,
    input  logic              ack
);

    localparam int unsigned AB    = ADDR_W / 8;
    localparam int unsigned WB    = DATA_W / 8;
    localparam int unsigned NB    = AB + WB;
    localparam int unsigned CNT_W = $clog2(NB + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned PAY_W = ADDR_W + DATA_W;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);
    localparam logic [CNT_W-1:0] FIRST_DB  = CNT_W'(AB);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    localparam logic [1:0] PH_ADDR  = 2'b00;
    localparam logic [1:0] PH_WDATA = 2'b01;
    localparam logic [1:0] PH_RDATA = 2'b10;
    localparam logic [1:0] PH_IDLE  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  beat_q, beat_d, beat_nx;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_m, ack_s;
    logic [CNT_W+2:0]  rd_sh;
    logic              go_done, abort;

    logic [DATA_W-1:0] data_out_d;
    logic              memory_ready_d, write_complete_d, bus_error_d, busy_d;
    logic [7:0]        bus_out_d, bus_oe_d;
    logic              strobe_d;
    logic [1:0]        phase_d;

    // Byte k of the {data, address} payload; address occupies the low beats.
    function automatic logic [7:0] beat_byte(input logic [CNT_W-1:0] k,
                                             input logic [PAY_W-1:0] pay);
        return 8'(pay >> {k, 3'b000});
    endfunction

    function automatic logic [1:0] beat_phase(input logic [CNT_W-1:0] k, input logic wr);
        if (k < FIRST_DB) return PH_ADDR;
        return wr ? PH_WDATA : PH_RDATA;
    endfunction

    assign beat_nx = beat_q + 1'b1;
    assign rd_sh   = {beat_q - FIRST_DB, 3'b000};

    // ack arrives from another domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= ack;
            ack_s <= ack_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            beat_q         <= '0;
            tmo_q          <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wr_q           <= 1'b0;
            rdata_q        <= '0;
            data_out       <= '0;
            memory_ready   <= 1'b0;
            write_complete <= 1'b0;
            bus_error      <= 1'b0;
            busy           <= 1'b0;
            bus_out        <= 8'h00;
            bus_oe         <= 8'h00;
            strobe         <= 1'b0;
            phase          <= PH_IDLE;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            tmo_q          <= tmo_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wr_q           <= wr_d;
            rdata_q        <= rdata_d;
            data_out       <= data_out_d;
            memory_ready   <= memory_ready_d;
            write_complete <= write_complete_d;
            bus_error      <= bus_error_d;
            busy           <= busy_d;
            bus_out        <= bus_out_d;
            bus_oe         <= bus_oe_d;
            strobe         <= strobe_d;
            phase          <= phase_d;
        end
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        tmo_d            = tmo_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        wr_d             = wr_q;
        rdata_d          = rdata_q;
        data_out_d       = data_out;
        memory_ready_d   = 1'b0;
        write_complete_d = 1'b0;
        bus_error_d      = 1'b0;
        busy_d           = busy;
        bus_out_d        = bus_out;
        bus_oe_d         = bus_oe;
        strobe_d         = 1'b0;
        phase_d          = phase;
        go_done          = 1'b0;
        abort            = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (request) begin
                    addr_d    = request_address;
                    wdata_d   = memory_write;
                    wr_d      = request_type;
                    beat_d    = '0;
                    busy_d    = 1'b1;
                    bus_out_d = beat_byte('0, {memory_write, request_address});
                    bus_oe_d  = 8'hFF;
                    phase_d   = PH_ADDR;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                strobe_d = 1'b1;
                tmo_d    = '0;
                state_d  = S_STROBE;
            end
            S_STROBE: begin
                if (ack_s) begin
                    if (!wr_q && beat_q >= FIRST_DB) begin
                        rdata_d = (rdata_q & ~(DATA_W'(8'hFF) << rd_sh))
                                | (DATA_W'(bus_in) << rd_sh);
                    end
                    tmo_d   = '0;
                    state_d = S_RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    abort   = 1'b1;
                    go_done = 1'b1;
                end else begin
                    tmo_d    = tmo_q + 1'b1;
                    strobe_d = 1'b1;
                end
            end
            S_RELEASE: begin
                if (!ack_s) begin
                    if (beat_q == LAST_BEAT) begin
                        go_done = 1'b1;
                    end else begin
                        beat_d    = beat_nx;
                        bus_out_d = beat_byte(beat_nx, {wdata_q, addr_q});
                        phase_d   = beat_phase(beat_nx, wr_q);
                        bus_oe_d  = (beat_phase(beat_nx, wr_q) == PH_RDATA) ? 8'h00 : 8'hFF;
                        state_d   = S_SETUP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    abort   = 1'b1;
                    go_done = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Completion (normal or aborted): release pins and pulse the done flags
        if (go_done) begin
            state_d          = S_DONE;
            strobe_d         = 1'b0;
            bus_oe_d         = 8'h00;
            phase_d          = PH_IDLE;
            memory_ready_d   = !wr_q;
            write_complete_d = wr_q;
            bus_error_d      = abort;
            if (!wr_q && !abort) data_out_d = rdata_q;
        end
    end

endmodule

// File: tb/tb_ext_mem_bridge_n.sv
// Scoreboard bench for ext_mem_bridge_n: 16/16 instance for handshake, timeout and reset
// cases, and a 32/24 instance for wider beat sequences.
module tb_ext_mem_bridge_n;

    localparam int unsigned TMO = 12;

    typedef struct packed {
        logic       chk;
        logic [7:0] b;
        logic [1:0] ph;
        logic [7:0] oe;
    } beat_t;

    typedef struct packed {
        logic        wr;
        logic        err;
        logic [31:0] dout;
        logic [15:0] cyc;
    } done_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req0 = 1'b0, typ0 = 1'b0;
    logic [15:0] addr0 = '0, wdat0 = '0, dout0;
    logic        mr0, wc0, be0, busy0, stb0;
    logic [7:0]  bo0, oe0;
    logic [7:0]  bi0 = '0;
    logic [1:0]  ph0;
    logic        ack0 = 1'b0;

    logic        req1 = 1'b0, typ1 = 1'b0;
    logic [23:0] addr1 = '0;
    logic [31:0] wdat1 = '0, dout1;
    logic        mr1, wc1, be1, busy1, stb1;
    logic [7:0]  bo1, oe1;
    logic [7:0]  bi1 = '0;
    logic [1:0]  ph1;
    logic        ack1 = 1'b0;

    ext_mem_bridge_n #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TMO)) u0 (
        .clk(clk), .reset(reset), .request(req0), .request_type(typ0),
        .request_address(addr0), .memory_write(wdat0), .data_out(dout0),
        .memory_ready(mr0), .write_complete(wc0), .bus_error(be0), .busy(busy0),
        .bus_out(bo0), .bus_oe(oe0), .bus_in(bi0), .strobe(stb0), .phase(ph0), .ack(ack0)
    );

    ext_mem_bridge_n #(.DATA_W(32), .ADDR_W(24), .TIMEOUT(TMO)) u1 (
        .clk(clk), .reset(reset), .request(req1), .request_type(typ1),
        .request_address(addr1), .memory_write(wdat1), .data_out(dout1),
        .memory_ready(mr1), .write_complete(wc1), .bus_error(be1), .busy(busy1),
        .bus_out(bo1), .bus_oe(oe1), .bus_in(bi1), .strobe(stb1), .phase(ph1), .ack(ack1)
    );

    int checks = 0;
    int errors = 0;
    beat_t      bq0[$], bq1[$];
    done_t      dq0[$], dq1[$];
    logic [7:0] rq0[$], rq1[$];
    int   mode0 = 0, mode1 = 0;
    logic stb0_p = 1'b0, stb1_p = 1'b0;
    int   cyc0 = 0, cyc1 = 0;
    int   stall_cnt = 0;
    logic fin_req = 1'b0, fin_ack = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic void check_beat(input string tag, input beat_t e, input logic [7:0] b,
                                       input logic [1:0] ph, input logic [7:0] oe);
        chk({tag, "_phase"}, 64'(ph), 64'(e.ph));
        chk({tag, "_oe"}, 64'(oe), 64'(e.oe));
        if (e.chk) chk({tag, "_byte"}, 64'(b), 64'(e.b));
    endfunction

    function automatic void check_done(input string tag, input done_t e, input logic mr,
                                       input logic wc, input logic be, input logic [31:0] dout,
                                       input logic stb, input logic [7:0] oe, input logic [1:0] ph,
                                       input logic bsy, input int cyc);
        chk({tag, "_kind"}, 64'({mr, wc}), e.wr ? 64'd1 : 64'd2);
        chk({tag, "_err"}, 64'(be), 64'(e.err));
        chk({tag, "_data"}, 64'(dout), 64'(e.dout));
        chk({tag, "_pins"}, 64'({stb, oe, ph, bsy}), 64'({1'b0, 8'h00, 2'b11, 1'b1}));
        chk({tag, "_cycles"}, 64'(cyc), 64'(e.cyc));
    endfunction

    // Monitor + responder: all checking and ack/bus_in driving happens here
    always @(negedge clk) begin
        if (!reset) begin
            chk("reset0", 64'({dout0, mr0, wc0, be0, busy0, bo0, oe0, stb0, ph0}),
                64'({16'h0, 4'b0, 8'h00, 8'h00, 1'b0, 2'b11}));
            chk("reset1", 64'({dout1, mr1, wc1, be1, busy1, bo1, oe1, stb1, ph1}),
                64'({32'h0, 4'b0, 8'h00, 8'h00, 1'b0, 2'b11}));
            cyc0 = 0;
            cyc1 = 0;
        end else begin
            if (stb0 && !stb0_p) begin
                chk("beat0_queued", 64'(bq0.size() > 0), 64'd1);
                if (bq0.size() > 0) check_beat("beat0", bq0.pop_front(), bo0, ph0, oe0);
                if (ph0 == 2'b10) begin
                    chk("rd0_queued", 64'(rq0.size() > 0), 64'd1);
                    if (rq0.size() > 0) bi0 = rq0.pop_front();
                end
            end
            if (mr0 || wc0) begin
                chk("done0_queued", 64'(dq0.size() > 0), 64'd1);
                if (dq0.size() > 0)
                    check_done("done0", dq0.pop_front(), mr0, wc0, be0, 32'(dout0),
                               stb0, oe0, ph0, busy0, cyc0);
                cyc0 = 0;
            end else if (busy0) begin
                cyc0++;
            end

            if (stb1 && !stb1_p) begin
                chk("beat1_queued", 64'(bq1.size() > 0), 64'd1);
                if (bq1.size() > 0) check_beat("beat1", bq1.pop_front(), bo1, ph1, oe1);
                if (ph1 == 2'b10) begin
                    chk("rd1_queued", 64'(rq1.size() > 0), 64'd1);
                    if (rq1.size() > 0) bi1 = rq1.pop_front();
                end
            end
            if (mr1 || wc1) begin
                chk("done1_queued", 64'(dq1.size() > 0), 64'd1);
                if (dq1.size() > 0)
                    check_done("done1", dq1.pop_front(), mr1, wc1, be1, dout1,
                               stb1, oe1, ph1, busy1, cyc1);
                cyc1 = 0;
            end else if (busy1) begin
                cyc1++;
            end
        end

        case (mode0)
            1:       ack0 = 1'b0;
            2:       if (stb0) ack0 = 1'b1;
            default: ack0 = stb0;
        endcase
        case (mode1)
            1:       ack1 = 1'b0;
            2:       if (stb1) ack1 = 1'b1;
            default: ack1 = stb1;
        endcase
        stb0_p = stb0;
        stb1_p = stb1;

        if (fin_req && !fin_ack) begin
            chk("beatq0_drained", 64'(bq0.size()), 64'd0);
            chk("doneq0_drained", 64'(dq0.size()), 64'd0);
            chk("rdq0_drained", 64'(rq0.size()), 64'd0);
            chk("beatq1_drained", 64'(bq1.size()), 64'd0);
            chk("doneq1_drained", 64'(dq1.size()), 64'd0);
            chk("rdq1_drained", 64'(rq1.size()), 64'd0);
            chk("wait_bounds", 64'(stall_cnt), 64'd0);
            fin_ack = 1'b1;
        end
    end

    task automatic pb0(input logic c, input logic [7:0] b, input logic [1:0] ph, input logic [7:0] oe);
        bq0.push_back({c, b, ph, oe});
    endtask

    task automatic pb1(input logic c, input logic [7:0] b, input logic [1:0] ph, input logic [7:0] oe);
        bq1.push_back({c, b, ph, oe});
    endtask

    task automatic pd0(input logic wr, input logic err, input logic [31:0] d, input logic [15:0] cyc);
        dq0.push_back({wr, err, d, cyc});
    endtask

    task automatic pd1(input logic wr, input logic err, input logic [31:0] d, input logic [15:0] cyc);
        dq1.push_back({wr, err, d, cyc});
    endtask

    task automatic go0(input logic wr, input logic [15:0] a, input logic [15:0] d);
        typ0 = wr; addr0 = a; wdat0 = d; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
    endtask

    task automatic go1(input logic wr, input logic [23:0] a, input logic [31:0] d);
        typ1 = wr; addr1 = a; wdat1 = d; req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
    endtask

    task automatic wait_done0();
        int n = 0;
        while (!(mr0 || wc0) && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) stall_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done1();
        int n = 0;
        while (!(mr1 || wc1) && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) stall_cnt++;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);

        // Write 0x1234 <- 0xBEEF
        pb0(1, 8'h34, 2'b00, 8'hFF); pb0(1, 8'h12, 2'b00, 8'hFF);
        pb0(1, 8'hEF, 2'b01, 8'hFF); pb0(1, 8'hBE, 2'b01, 8'hFF);
        pd0(1, 0, 32'h0, 16'd28);
        go0(1, 16'h1234, 16'hBEEF);
        wait_done0();

        // Read 0x00FF, responder returns CD then BE
        pb0(1, 8'hFF, 2'b00, 8'hFF); pb0(1, 8'h00, 2'b00, 8'hFF);
        pb0(0, 8'h00, 2'b10, 8'h00); pb0(0, 8'h00, 2'b10, 8'h00);
        rq0.push_back(8'hCD); rq0.push_back(8'hBE);
        pd0(0, 0, 32'hBECD, 16'd28);
        go0(0, 16'h00FF, 16'h0000);
        wait_done0();

        // Wide instance: 3 address + 4 data beats
        pb1(1, 8'h56, 2'b00, 8'hFF); pb1(1, 8'h34, 2'b00, 8'hFF); pb1(1, 8'h12, 2'b00, 8'hFF);
        pb1(1, 8'hEF, 2'b01, 8'hFF); pb1(1, 8'hBE, 2'b01, 8'hFF);
        pb1(1, 8'hAD, 2'b01, 8'hFF); pb1(1, 8'hDE, 2'b01, 8'hFF);
        pd1(1, 0, 32'h0, 16'd49);
        go1(1, 24'h123456, 32'hDEADBEEF);
        wait_done1();

        pb1(1, 8'hEF, 2'b00, 8'hFF); pb1(1, 8'hCD, 2'b00, 8'hFF); pb1(1, 8'hAB, 2'b00, 8'hFF);
        for (int i = 0; i < 4; i++) pb1(0, 8'h00, 2'b10, 8'h00);
        rq1.push_back(8'h11); rq1.push_back(8'h22); rq1.push_back(8'h33); rq1.push_back(8'h44);
        pd1(0, 0, 32'h44332211, 16'd49);
        go1(0, 24'hABCDEF, 32'h0);
        wait_done1();

        // Write with ack tied low: abort in STROBE of beat 0
        mode0 = 1;
        pb0(1, 8'h0B, 2'b00, 8'hFF);
        pd0(1, 1, 32'hBECD, 16'(1 + TMO));
        go0(1, 16'h0A0B, 16'h1111);
        wait_done0();
        mode0 = 0;

        // Read where ack never falls: abort in RELEASE, data_out retained
        mode0 = 2;
        pb0(1, 8'h0D, 2'b00, 8'hFF);
        pd0(0, 1, 32'hBECD, 16'(4 + TMO));
        go0(0, 16'h0C0D, 16'h0000);
        wait_done0();
        mode0 = 0;
        repeat (4) @(negedge clk);

        // Reset during beat 2 of a write: no done pulse, then a clean transfer
        pb0(1, 8'h78, 2'b00, 8'hFF); pb0(1, 8'h56, 2'b00, 8'hFF); pb0(1, 8'hBC, 2'b01, 8'hFF);
        go0(1, 16'h5678, 16'h9ABC);
        n = 0;
        while (!(stb0 && ph0 == 2'b01) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) stall_cnt++;
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);

        pb0(1, 8'h21, 2'b00, 8'hFF); pb0(1, 8'h43, 2'b00, 8'hFF);
        pb0(1, 8'h65, 2'b01, 8'hFF); pb0(1, 8'h87, 2'b01, 8'hFF);
        pd0(1, 0, 32'h0, 16'd28);
        go0(1, 16'h4321, 16'h8765);
        wait_done0();

        // request toggled while busy, then held through DONE: exactly one more transfer
        pb0(1, 8'h01, 2'b00, 8'hFF); pb0(1, 8'h10, 2'b00, 8'hFF);
        pb0(1, 8'h02, 2'b01, 8'hFF); pb0(1, 8'h20, 2'b01, 8'hFF);
        pd0(1, 0, 32'h0, 16'd28);
        pb0(1, 8'h03, 2'b00, 8'hFF); pb0(1, 8'h30, 2'b00, 8'hFF);
        pb0(0, 8'h00, 2'b10, 8'h00); pb0(0, 8'h00, 2'b10, 8'h00);
        rq0.push_back(8'h5A); rq0.push_back(8'hA5);
        pd0(0, 0, 32'hA55A, 16'd28);
        typ0 = 1'b1; addr0 = 16'h1001; wdat0 = 16'h2002; req0 = 1'b1;
        @(negedge clk);
        typ0 = 1'b0; addr0 = 16'h3003; wdat0 = 16'h0000;
        for (int i = 0; i < 10; i++) begin req0 = ~req0; @(negedge clk); end
        req0 = 1'b1;
        n = 0;
        while (!wc0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) stall_cnt++;
        n = 0;
        while (busy0 && n < 10) begin @(negedge clk); n++; end
        if (n >= 10) stall_cnt++;
        n = 0;
        while (!busy0 && n < 10) begin @(negedge clk); n++; end
        if (n >= 10) stall_cnt++;
        req0 = 1'b0;
        wait_done0();
        repeat (20) @(negedge clk);

        fin_req = 1'b1;
        n = 0;
        while (!fin_ack && n < 10) begin @(negedge clk); n++; end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
